// File: rtl/multi_cycle_fsm.sv
// multi_cycle_fsm: phase sequencer for the multi-cycle MIPS core.
// Walks each instruction through IF/ID/EX/MEM/WB, drives the phase code
// for the control decoder, produces single-cycle commit strobes, waits on
// the memory ready handshakes and counts retired instructions.
module multi_cycle_fsm #(
  parameter int STATE_LEN = 3,
  parameter int CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic                 imem_ready,
  input  logic                 dmem_ready,
  output logic [STATE_LEN-1:0] state,
  output logic                 imem_req,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 dmem_req,
  output logic                 wb_en,
  output logic                 illegal_instr,
  output logic                 instr_retired,
  output logic [CNT_W-1:0]     retired_count
);

  // Phase codes; 5..7 are never entered but fall back to IF if seen.
  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EX  = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] count_reg;
  logic             is_alu;
  logic             is_mem;
  logic             is_legal;

  // Opcode classes; R-type with any funct counts as an ALU op.
  assign is_alu   = (opcode == OP_R) || (opcode == OP_ADDI) || (opcode == OP_ORI);
  assign is_mem   = (opcode == OP_LW) || (opcode == OP_SW);
  assign is_legal = is_alu || is_mem || (opcode == OP_BEQ) || (opcode == OP_J);

  assign state         = STATE_LEN'(state_reg);
  assign retired_count = count_reg;

  // Phase register; reset abandons the in-flight instruction at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IF;
    end else begin
      state_reg <= state_next;
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (instr_retired) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  // Next-phase selection and phase-qualified strobes, all muted during reset.
  always_comb begin
    state_next    = S_IF;
    imem_req      = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    dmem_req      = 1'b0;
    wb_en         = 1'b0;
    illegal_instr = 1'b0;
    instr_retired = 1'b0;

    case (state_reg)
      S_IF: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          state_next = S_ID;
        end else begin
          state_next = S_IF;
        end
      end
      S_ID: begin
        if (opcode == OP_J) begin
          pc_write      = 1'b1;
          instr_retired = 1'b1;
          state_next    = S_IF;
        end else if (!is_legal) begin
          // Acts as a nop: PC already advanced in IF, nothing retires.
          illegal_instr = 1'b1;
          state_next    = S_IF;
        end else begin
          state_next = S_EX;
        end
      end
      S_EX: begin
        if (opcode == OP_BEQ) begin
          pc_write_cond = 1'b1;
          instr_retired = 1'b1;
          state_next    = S_IF;
        end else if (is_mem) begin
          state_next = S_MEM;
        end else if (is_alu) begin
          state_next = S_WB;
        end else begin
          state_next = S_IF;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          if (opcode == OP_SW) begin
            instr_retired = 1'b1;
            state_next    = S_IF;
          end else begin
            state_next = S_WB;
          end
        end else begin
          state_next = S_MEM;
        end
      end
      S_WB: begin
        wb_en         = 1'b1;
        instr_retired = 1'b1;
        state_next    = S_IF;
      end
      default: begin
        state_next = S_IF;
      end
    endcase

    if (rst) begin
      imem_req      = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      dmem_req      = 1'b0;
      wb_en         = 1'b0;
      illegal_instr = 1'b0;
      instr_retired = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_cycle_fsm.sv
// Bench for multi_cycle_fsm: per-cycle vector table plus hand-written
// reset and counter-wrap sequences. Expected per-cycle outputs are queued
// when inputs are driven and popped/compared at the following negedge.
// A second instance with a 4-bit counter shares all stimulus.
module tb_multi_cycle_fsm;

  // Strobe bus bit order: imem_req, ir_write, pc_write, pc_write_cond,
  // dmem_req, wb_en, illegal_instr, instr_retired
  localparam logic [7:0] IMEM  = 8'h80;
  localparam logic [7:0] IRW   = 8'h40;
  localparam logic [7:0] PCW   = 8'h20;
  localparam logic [7:0] PCC   = 8'h10;
  localparam logic [7:0] DMR   = 8'h08;
  localparam logic [7:0] WBE   = 8'h04;
  localparam logic [7:0] ILL   = 8'h02;
  localparam logic [7:0] RET   = 8'h01;
  localparam logic [7:0] FETCH = 8'he0;
  localparam logic [7:0] NONE  = 8'h00;

  typedef struct {
    logic [5:0] op;
    logic       ir;
    logic       dr;
    logic [2:0] st;
    logic [7:0] sb;
    int         cnt;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [5:0]  opcode;
  logic        imem_ready;
  logic        dmem_ready;

  logic [2:0]  st_a;
  logic        imem_req_a, ir_write_a, pc_write_a, pc_write_cond_a;
  logic        dmem_req_a, wb_en_a, illegal_instr_a, instr_retired_a;
  logic [31:0] cnt_a;

  logic [2:0]  st_b;
  logic        imem_req_b, ir_write_b, pc_write_b, pc_write_cond_b;
  logic        dmem_req_b, wb_en_b, illegal_instr_b, instr_retired_b;
  logic [3:0]  cnt_b;

  logic [7:0]  sb_a;
  logic [7:0]  sb_b;

  int total;
  int bad;

  vec_t tbl[$];
  vec_t sb_q[$];

  multi_cycle_fsm #(.STATE_LEN(3), .CNT_W(32)) dut_a (
    .clk(clk), .rst(rst), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .state(st_a), .imem_req(imem_req_a), .ir_write(ir_write_a),
    .pc_write(pc_write_a), .pc_write_cond(pc_write_cond_a),
    .dmem_req(dmem_req_a), .wb_en(wb_en_a),
    .illegal_instr(illegal_instr_a), .instr_retired(instr_retired_a),
    .retired_count(cnt_a)
  );

  multi_cycle_fsm #(.STATE_LEN(3), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .opcode(opcode),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .state(st_b), .imem_req(imem_req_b), .ir_write(ir_write_b),
    .pc_write(pc_write_b), .pc_write_cond(pc_write_cond_b),
    .dmem_req(dmem_req_b), .wb_en(wb_en_b),
    .illegal_instr(illegal_instr_b), .instr_retired(instr_retired_b),
    .retired_count(cnt_b)
  );

  assign sb_a = {imem_req_a, ir_write_a, pc_write_a, pc_write_cond_a,
                 dmem_req_a, wb_en_a, illegal_instr_a, instr_retired_a};
  assign sb_b = {imem_req_b, ir_write_b, pc_write_b, pc_write_cond_b,
                 dmem_req_b, wb_en_b, illegal_instr_b, instr_retired_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic ir, input logic dr,
                     input logic [2:0] st, input logic [7:0] sb, input int cnt);
    vec_t v;
    v.op = op; v.ir = ir; v.dr = dr; v.st = st; v.sb = sb; v.cnt = cnt;
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs and queue what the DUT must show for it.
  task automatic drive(input vec_t v);
    opcode     = v.op;
    imem_ready = v.ir;
    dmem_ready = v.dr;
    sb_q.push_back(v);
  endtask

  // Pop the oldest expectation and compare both instances against it.
  task automatic check(input string tag);
    vec_t e;
    if (sb_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty got 0 want 1", tag);
    end else begin
      e = sb_q.pop_front();
      cmp({tag, " state"},  32'(st_a), 32'(e.st));
      cmp({tag, " strobe"}, 32'(sb_a), 32'(e.sb));
      cmp({tag, " count"},  cnt_a, 32'(e.cnt));
      cmp({tag, " state4"}, 32'(st_b), 32'(e.st));
      cmp({tag, " strobe4"}, 32'(sb_b), 32'(e.sb));
      cmp({tag, " count4"}, 32'(cnt_b), 32'(e.cnt % 16));
      $display("cyc %s op=%02h ir=%0b dr=%0b state=%0d strobes=%02h count=%0d count4=%0d",
               tag, opcode, imem_ready, dmem_ready, st_a, sb_a, cnt_a, cnt_b);
    end
  endtask

  // One full cycle: drive after the rising edge, check at the falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    drive(v);
    @(negedge clk);
    check(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    total = 0;
    bad   = 0;
    rst        = 1'b1;
    opcode     = 6'h00;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;

    // Main table: R, lw with 3 wait cycles, j/beq/sw, illegal, IF stall, addi, ori.
    add(6'h3f,1,0,0,FETCH,0); add(6'h00,1,0,1,NONE,0); add(6'h00,1,0,2,NONE,0);
    add(6'h00,1,0,4,WBE|RET,0);
    add(6'h3f,1,0,0,FETCH,1); add(6'h23,1,0,1,NONE,1); add(6'h23,1,0,2,NONE,1);
    add(6'h23,1,0,3,DMR,1);   add(6'h23,1,0,3,DMR,1);  add(6'h23,1,0,3,DMR,1);
    add(6'h23,1,1,3,DMR,1);   add(6'h23,1,1,4,WBE|RET,1);
    add(6'h3f,1,0,0,FETCH,2); add(6'h02,1,1,1,PCW|RET,2);
    add(6'h3f,1,0,0,FETCH,3); add(6'h04,1,0,1,NONE,3); add(6'h04,1,0,2,PCC|RET,3);
    add(6'h3f,1,0,0,FETCH,4); add(6'h2b,1,0,1,NONE,4); add(6'h2b,1,0,2,NONE,4);
    add(6'h2b,1,1,3,DMR|RET,4);
    add(6'h00,1,0,0,FETCH,5); add(6'h3f,1,0,1,ILL,5);
    for (int i = 0; i < 5; i++) add(6'h00,0,1,0,IMEM,5);
    add(6'h00,1,0,0,FETCH,5); add(6'h08,1,0,1,NONE,5); add(6'h08,1,0,2,NONE,5);
    add(6'h08,1,0,4,WBE|RET,5);
    add(6'h0d,1,0,0,FETCH,6); add(6'h0d,1,0,1,NONE,6); add(6'h0d,1,0,2,NONE,6);
    add(6'h0d,1,0,4,WBE|RET,6);
    add(6'h00,0,0,0,IMEM,7);

    // Reset state: everything quiet even with ready inputs high.
    v.op = 6'h00; v.ir = 1'b1; v.dr = 1'b1; v.st = 3'd0; v.sb = NONE; v.cnt = 0;
    drive(v);
    @(negedge clk);
    @(negedge clk);
    check("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("t%0d", i));
    end

    // sw interrupted by asynchronous reset while stalled in MEM.
    v.op = 6'h2b; v.ir = 1'b1; v.dr = 1'b0; v.st = 3'd0; v.sb = FETCH; v.cnt = 7;
    run_vec(v, "sw_if");
    v.st = 3'd1; v.sb = NONE;
    run_vec(v, "sw_id");
    v.st = 3'd2;
    run_vec(v, "sw_ex");
    v.st = 3'd3; v.sb = DMR;
    drive(v);
    @(negedge clk);
    check("sw_mem");
    #2;
    rst = 1'b1;
    dmem_ready = 1'b1;
    v.st = 3'd0; v.sb = NONE; v.cnt = 0;
    sb_q.push_back(v);
    #1;
    check("async_rst");
    @(posedge clk);
    #1;
    sb_q.push_back(v);
    check("rst_hold");
    rst = 1'b0;

    // 17 back-to-back R-type instructions: 4-bit counter goes 15, 0, 1.
    for (int n = 0; n < 17; n++) begin
      v.op = 6'h00; v.ir = 1'b1; v.dr = 1'b0; v.cnt = n;
      v.st = 3'd0; v.sb = FETCH;    run_vec(v, $sformatf("w%0d_if", n));
      v.st = 3'd1; v.sb = NONE;     run_vec(v, $sformatf("w%0d_id", n));
      v.st = 3'd2; v.sb = NONE;     run_vec(v, $sformatf("w%0d_ex", n));
      v.st = 3'd4; v.sb = WBE|RET;  run_vec(v, $sformatf("w%0d_wb", n));
    end
    v.op = 6'h00; v.ir = 1'b0; v.dr = 1'b0; v.st = 3'd0; v.sb = IMEM; v.cnt = 17;
    run_vec(v, "w_end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_cycle_fsm.md
# multi_cycle_fsm

Sequencer for the multi-period MIPS core. It steps each instruction through the fetch, decode, execute, memory and write-back phases, and drives the `state` bus consumed by the control-signal decoder. It also generates the phase-qualified strobes (IR/PC write, memory requests, write-back enable) that the decoder's level flags need to become single commits. It waits on the instruction-memory and data-memory ready handshakes, flags illegal opcodes and counts retired instructions.

## Interface
- `STATE_LEN`, 3, width of the state bus; must match the decoder's `state` input.
- `CNT_W`, 32, width of the retired-instruction counter.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `opcode` input 6: instr[31:26] from the instruction register; valid from ID onward, ignored in IF.
- `imem_ready` input 1: instruction memory has valid data this cycle.
- `dmem_ready` input 1: data-memory access completes this cycle.
- `state` output STATE_LEN: current phase; IF=0, ID=1, EX=2, MEM=3, WB=4; codes 5–7 are unused.
- `imem_req` output 1: fetch request.
- `ir_write` output 1: latch fetched instruction into IR.
- `pc_write` output 1: unconditional PC update (PC+4 in IF, jump target in ID).
- `pc_write_cond` output 1: PC update if ALU zero (beq).
- `dmem_req` output 1: data-memory access request (lw/sw).
- `wb_en` output 1: register-file write commit.
- `illegal_instr` output 1: one-cycle pulse, unknown opcode in ID.
- `instr_retired` output 1: one-cycle pulse on an instruction's final cycle.
- `retired_count` output CNT_W: retired instructions since reset.

## Operation
- State register plus counter are the only flops. All strobes are combinational from (state, opcode, ready) and are forced 0 while `rst`=1.
- Opcodes:
  - R=000000, addi=001000, ori=001101, beq=000100, j=000010, lw=100011, sw=101011.
  - Any other opcode is illegal.
- IF:
  - `imem_req`=1 every cycle.
  - When `imem_ready`=1: `ir_write`=1, `pc_write`=1, next state is ID.
  - Otherwise remain in IF.
- ID:
  - j: `pc_write`=1, `instr_retired`=1, next state is IF.
  - Illegal: `illegal_instr`=1, no retire, next state is IF. The illegal instruction behaves as a nop, and PC has already advanced.
  - All other legal opcodes: next state is EX.
- EX:
  - beq: `pc_write_cond`=1, `instr_retired`=1, next state is IF.
  - lw/sw: next state is MEM.
  - R/addi/ori: next state is WB.
- MEM:
  - `dmem_req`=1 every cycle.
  - When `dmem_ready`=1: sw retires and goes to IF; lw goes to WB.
  - Otherwise hold in MEM.
- WB: `wb_en`=1, `instr_retired`=1, next state is IF.
- Unused state codes: next state is IF, all strobes 0, no retire.
- `retired_count` increments by 1 on each edge where `instr_retired`=1. It wraps from 2^CNT_W−1 to 0.
- R-type with an unsupported funct still sequences as R-type. The decoder handles the ALU default.

## Timing
- Reset values:
  - `state`=IF(0), `retired_count`=0.
  - All strobes 0 while `rst` is high.
  - First `imem_req` appears in the first cycle after `rst` deassertion.
- `rst` asserted mid-instruction: the instruction is abandoned immediately, with no retire, no `wb_en` and no `dmem_req` after assertion.
- Cycles per instruction, including IF, with zero memory wait:
  - j: 2.
  - beq: 3.
  - R/addi/ori: 4.
  - sw: 4.
  - lw: 5.
  - Illegal: 2, with no retire.
- Each memory wait cycle adds 1.
- Ready handshake:
  - `imem_ready` is sampled only in IF; `dmem_ready` only in MEM.
  - Ready asserted outside those states has no effect.
  - Ready may be high in the first request cycle, giving zero wait.
- `ir_write` and `pc_write` in IF occur in the same cycle, exactly once per fetch.
- `wb_en` is asserted for exactly one cycle per R/addi/ori/lw instruction.

## Test plan
- Reset, then hold `imem_ready`=1 and feed opcode 000000: states 0,1,2,4,0; `wb_en` only in the state-4 cycle; `retired_count`=1 after 4 cycles.
- lw (100011) with `dmem_ready` low for 3 MEM cycles: states 0,1,2,3,3,3,3,4,0; `dmem_req` high for 4 cycles; retire after 8 cycles.
- Sequence j, beq, sw with zero wait: retire pulses at cycles 2, 5 and 9; `pc_write` in the j ID cycle; `pc_write_cond` in the beq EX cycle; `wb_en` never high.
- Opcode 111111: `illegal_instr` pulses in ID; `instr_retired`=0; `retired_count` unchanged; back in IF the next cycle.
- Assert `rst` during MEM of sw: `state` becomes 0 asynchronously, no `dmem_req` from that point, and `retired_count` is cleared.
- CNT_W=4 build running 17 R-type instructions: `retired_count` reads 15 then 0 then 1. Also stall `imem_ready` low for 5 cycles: `ir_write` stays 0 until ready.
